// File: rtl/traffic_pkg.sv
// Shared types for the traffic_control sandbox: lamp encoding and controller states.
package traffic_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  typedef enum logic [1:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_WALK
  } state_e;

endpackage

// File: rtl/rr_next_dir.sv
// Combinational round-robin finder: first approach with demand after active_dir,
// wrapping, with active_dir itself checked last; keeps active_dir if nobody waits.
module rr_next_dir #(
  parameter int unsigned N_DIR = 4,
  parameter int unsigned DIR_W = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] sensor,
  input  logic [DIR_W-1:0] active_dir,
  output logic [DIR_W-1:0] next_dir
);

  logic        found;
  int unsigned idx;

  always_comb begin
    next_dir = active_dir;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= N_DIR; k++) begin
      idx = (int'(active_dir) + k) % N_DIR;
      if (!found && sensor[idx]) begin
        found    = 1'b1;
        next_dir = DIR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-approach round-robin traffic light controller with min/max green, yellow,
// all-red clearance and a latched pedestrian walk phase. All outputs registered.
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int unsigned N_DIR      = 4,
  parameter int unsigned DIR_W      = $clog2(N_DIR),
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned MAX_GREEN  = 32,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned WALK_CYC   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DIR-1:0]   sensor,
  input  logic               ped_req,
  output logic [2*N_DIR-1:0] lights,
  output logic [DIR_W-1:0]   active_dir,
  output logic               ped_walk
);

  localparam logic [CNT_W-1:0] MinG   = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MaxG   = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YelEnd = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] RedEnd = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WlkEnd = CNT_W'(WALK_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               ped_q, ped_d;
  logic [2*N_DIR-1:0] lights_q, lights_d;
  logic               walk_q, walk_d;

  logic [DIR_W-1:0]   next_dir;
  logic [N_DIR-1:0]   own_mask;
  logic               other_demand;

  rr_next_dir #(
    .N_DIR (N_DIR),
    .DIR_W (DIR_W)
  ) u_rr (
    .sensor     (sensor),
    .active_dir (dir_q),
    .next_dir   (next_dir)
  );

  assign own_mask     = N_DIR'(1) << dir_q;
  assign other_demand = (|(sensor & ~own_mask)) | ped_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_GREEN: begin
        if (timer_q >= MinG && other_demand && (!sensor[dir_q] || timer_q >= MaxG)) begin
          state_d = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (timer_q == YelEnd) state_d = S_ALLRED;
      end
      S_ALLRED: begin
        if (timer_q == RedEnd) begin
          if (ped_q) begin
            state_d = S_WALK;
          end else begin
            state_d = S_GREEN;
            dir_d   = next_dir;
          end
        end
      end
      S_WALK: begin
        if (timer_q == WlkEnd) begin
          state_d = S_GREEN;
          dir_d   = next_dir;
        end
      end
      default: state_d = S_ALLRED;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == S_GREEN && timer_q == MaxG) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    // Entering WALK consumes the request, even against a same-cycle press.
    if (state_d == S_WALK && state_q != S_WALK) begin
      ped_d = 1'b0;
    end else begin
      ped_d = ped_q | ped_req;
    end
  end

  // Outputs are decoded from next state so the registered lamps track the FSM.
  always_comb begin
    lights_d = '0;
    for (int unsigned i = 0; i < N_DIR; i++) begin
      if (dir_d == DIR_W'(i) && state_d == S_GREEN) begin
        lights_d[2*i +: 2] = LIGHT_GREEN;
      end else if (dir_d == DIR_W'(i) && state_d == S_YELLOW) begin
        lights_d[2*i +: 2] = LIGHT_YELLOW;
      end else begin
        lights_d[2*i +: 2] = LIGHT_RED;
      end
    end
    walk_d = (state_d == S_WALK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_ALLRED;
      timer_q  <= '0;
      dir_q    <= '0;
      ped_q    <= 1'b0;
      lights_q <= {N_DIR{LIGHT_RED}};
      walk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      dir_q    <= dir_d;
      ped_q    <= ped_d;
      lights_q <= lights_d;
      walk_q   <= walk_d;
    end
  end

  assign lights     = lights_q;
  assign active_dir = dir_q;
  assign ped_walk   = walk_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed bench for traffic_ctrl_n with default parameters (4 approaches).
module tb_traffic_ctrl_n;

  localparam logic [7:0] L_ALLRED = 8'b10101010;
  localparam logic [7:0] L_G0     = 8'b10101000;
  localparam logic [7:0] L_Y0     = 8'b10101001;
  localparam logic [7:0] L_G1     = 8'b10100010;
  localparam logic [7:0] L_G2     = 8'b10001010;

  logic       clk;
  logic       reset;
  logic [3:0] sensor;
  logic       ped_req;
  logic [7:0] lights;
  logic [1:0] active_dir;
  logic       ped_walk;

  int n_tests;
  int n_fail;

  traffic_ctrl_n dut (
    .clk        (clk),
    .reset      (reset),
    .sensor     (sensor),
    .ped_req    (ped_req),
    .lights     (lights),
    .active_dir (active_dir),
    .ped_walk   (ped_walk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check lamps/walk at the current negedge for n cycles, advancing one cycle each.
  task automatic phase(input string tag, input int n, input logic [7:0] l, input logic w);
    for (int i = 0; i < n; i++) begin
      check(tag, {24'd0, lights}, {24'd0, l});
      check({tag, "_walk"}, {31'd0, ped_walk}, {31'd0, w});
      @(negedge clk);
    end
  endtask

  // Reset, release, and return at the negedge right after dir0 turns green.
  task automatic reset_to_green();
    reset   = 1'b0;
    sensor  = 4'b0000;
    ped_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lights", {24'd0, lights}, {24'd0, L_ALLRED});
    check("rst_dir", {30'd0, active_dir}, 32'd0);
    check("rst_walk", {31'd0, ped_walk}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_allred", {24'd0, lights}, {24'd0, L_ALLRED});
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    sensor  = 4'b0000;
    ped_req = 1'b0;

    // Handoff to dir2.
    reset_to_green();
    sensor = 4'b0100;
    phase("ho_green", 8, L_G0, 1'b0);
    phase("ho_yellow", 3, L_Y0, 1'b0);
    phase("ho_allred", 2, L_ALLRED, 1'b0);
    check("ho_dir", {30'd0, active_dir}, 32'd2);
    phase("ho_g2", 3, L_G2, 1'b0);

    // Idle: dir0 holds green indefinitely.
    reset_to_green();
    phase("idle_green", 100, L_G0, 1'b0);
    check("idle_dir", {30'd0, active_dir}, 32'd0);

    // Max green with own sensor held and demand on dir1.
    reset_to_green();
    sensor = 4'b0011;
    phase("mx_green", 32, L_G0, 1'b0);
    phase("mx_yellow", 3, L_Y0, 1'b0);
    phase("mx_allred", 2, L_ALLRED, 1'b0);
    check("mx_dir", {30'd0, active_dir}, 32'd1);
    phase("mx_g1", 1, L_G1, 1'b0);

    // Pedestrian: single-cycle press, no vehicles.
    reset_to_green();
    sensor  = 4'b0000;
    ped_req = 1'b1;
    phase("pd_green0", 1, L_G0, 1'b0);
    ped_req = 1'b0;
    phase("pd_green", 7, L_G0, 1'b0);
    phase("pd_yellow", 3, L_Y0, 1'b0);
    phase("pd_allred", 2, L_ALLRED, 1'b0);
    phase("pd_walk", 6, L_ALLRED, 1'b1);
    check("pd_dir", {30'd0, active_dir}, 32'd0);
    phase("pd_after", 20, L_G0, 1'b0);

    // Mid-yellow asynchronous reset drops the pending request.
    reset_to_green();
    sensor  = 4'b0100;
    ped_req = 1'b1;
    phase("mr_green0", 1, L_G0, 1'b0);
    ped_req = 1'b0;
    phase("mr_green", 7, L_G0, 1'b0);
    check("mr_yellow", {24'd0, lights}, {24'd0, L_Y0});
    #2;
    reset  = 1'b0;
    sensor = 4'b0000;
    #1;
    check("mr_async_lights", {24'd0, lights}, {24'd0, L_ALLRED});
    check("mr_async_walk", {31'd0, ped_walk}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_rel_allred", {24'd0, lights}, {24'd0, L_ALLRED});
    @(negedge clk);
    phase("mr_green_after", 12, L_G0, 1'b0);
    check("mr_dir", {30'd0, active_dir}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
